// File: rtl/uart_tx_arbiter_if.sv
// Byte-source and uart_tx side signals of the shared transmitter arbiter.
// The slave modport is the arbiter; the master modport drives sources and cts.
interface uart_tx_arbiter_if #(
    parameter int NR = 4
) ();
    localparam int GW = $clog2(NR);

    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic            tx_req;
    logic [7:0]      tx_data;
    logic            tx_cts;
    logic [GW-1:0]   grant_ret;
    logic            busy_ret;

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        output req_ready,
        output tx_req,
        output tx_data,
        input  tx_cts,
        output grant_ret,
        output busy_ret
    );

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        input  req_ready,
        input  tx_req,
        input  tx_data,
        output tx_cts,
        input  grant_ret,
        input  busy_ret
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among several byte sources,
// with per-message channel locking and an optional stalled-lock timeout.
module uart_tx_arbiter #(
    parameter int num_requesters = 4,
    parameter int lock_timeout   = 16
) (
    input  logic              clock,
    input  logic              tick_i_rstn,
    uart_tx_arbiter_if.slave  bus
);
    localparam int N  = num_requesters;
    localparam int GW = $clog2(N);
    localparam int TW = (lock_timeout > 0) ? $clog2(lock_timeout + 1) : 1;
    localparam logic [TW-1:0] TMAX =
        TW'((lock_timeout > 0) ? lock_timeout - 1 : 0);
    localparam logic [GW-1:0] LAST_IDX = GW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_LOCK
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [GW-1:0]   r_rr_ptr;
    logic [GW-1:0]   r_grant;
    logic [7:0]      r_hold;
    logic            r_hold_last;
    logic [TW-1:0]   r_timer;

    logic            w_found;
    logic [GW-1:0]   w_win;
    logic [GW-1:0]   w_sel;
    logic [N-1:0]    w_ready;
    logic            w_xfer;
    logic            w_release;
    logic            w_timeout;
    logic [7:0]      w_data;
    logic [GW-1:0]   w_next_rr;

    // Rotating priority search starting at rr_ptr, wrapping at N-1
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(r_rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!w_found && bus.req_valid[idx]) begin
                w_found = 1'b1;
                w_win   = GW'(idx);
            end
        end
    end

    assign w_timeout = (lock_timeout != 0) && (r_timer == TMAX);
    assign w_next_rr = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_release   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_ready[w_win] = 1'b1;
                    w_state_nxt    = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.tx_cts) begin
                    if (r_hold_last) begin
                        w_state_nxt = S_IDLE;
                        w_release   = 1'b1;
                    end else begin
                        w_state_nxt = S_LOCK;
                    end
                end
            end
            S_LOCK: begin
                w_ready[r_grant] = 1'b1;
                if (bus.req_valid[r_grant]) begin
                    w_state_nxt = S_SEND;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_release   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (!tick_i_rstn) w_ready = '0;
    end

    assign w_xfer = |(bus.req_valid & w_ready);
    assign w_sel  = (r_state == S_LOCK) ? r_grant : w_win;
    assign w_data = bus.req_data[8*w_sel +: 8];

    always_ff @(posedge clock) begin
        if (!tick_i_rstn) r_state <= S_IDLE;
        else              r_state <= w_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (!tick_i_rstn) begin
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_hold      <= 8'h00;
            r_hold_last <= 1'b0;
            r_timer     <= '0;
        end else begin
            if (w_xfer) begin
                r_hold      <= w_data;
                r_hold_last <= bus.req_last[w_sel];
                r_grant     <= w_sel;
                r_timer     <= '0;
            end
            if (r_state == S_SEND && bus.tx_cts && !r_hold_last)
                r_timer <= '0;
            // Saturates at TMAX; release happens on that cycle
            if (r_state == S_LOCK && !w_xfer && lock_timeout != 0
                && r_timer != TMAX)
                r_timer <= r_timer + 1'b1;
            if (w_release)
                r_rr_ptr <= w_next_rr;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.tx_req    = (r_state == S_SEND);
    assign bus.tx_data   = (r_state == S_SEND) ? r_hold : 8'h00;
    assign bus.grant_ret = r_grant;
    assign bus.busy_ret  = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single byte, fairness,
// locking, timeout release and backpressure with reset mid-send.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic clock;
    logic tick_i_rstn;
    int   n_cmp;
    int   n_err;

    uart_tx_arbiter_if #(.NR(N)) bus ();

    uart_tx_arbiter #(
        .num_requesters(N),
        .lock_timeout(16)
    ) dut (
        .clock(clock),
        .tick_i_rstn(tick_i_rstn),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] d,
                           input logic l);
        bus.req_data[8*i +: 8] = d;
        bus.req_last[i]        = l;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        tick_i_rstn   = 1'b0;
        bus.req_valid = '1;
        bus.req_data  = '0;
        bus.req_last  = '1;
        bus.tx_cts    = 1'b1;

        // Reset
        tick();
        tick();
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_txreq", 32'(bus.tx_req), 32'h0);
        chk("rst_txdata", 32'(bus.tx_data), 32'h0);
        chk("rst_busy", 32'(bus.busy_ret), 32'h0);
        chk("rst_grant", 32'(bus.grant_ret), 32'h0);

        // Single byte from requester 0
        tick_i_rstn   = 1'b1;
        bus.req_valid = 4'b0001;
        set_req(0, 8'h55, 1'b1);
        #1;
        chk("single_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = '0;
        #1;
        chk("single_txreq", 32'(bus.tx_req), 32'h1);
        chk("single_txdata", 32'(bus.tx_data), 32'h55);
        chk("single_busy", 32'(bus.busy_ret), 32'h1);
        tick();
        chk("single_done", 32'(bus.tx_req), 32'h0);
        chk("single_idle", 32'(bus.busy_ret), 32'h0);
        chk("single_grant_hold", 32'(bus.grant_ret), 32'h0);

        // Fairness: rr_ptr is 1 now, so order 1,2,3,0,1
        for (int i = 0; i < N; i++) set_req(i, 8'(8'h10 + i), 1'b1);
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int exp_g;
            exp_g = (k + 1) % N;
            #1;
            chk("fair_ready", 32'(bus.req_ready), 32'(1 << exp_g));
            tick();
            chk("fair_grant", 32'(bus.grant_ret), 32'(exp_g));
            chk("fair_data", 32'(bus.tx_data), 32'(8'h10 + exp_g));
            chk("fair_noready", 32'(bus.req_ready), 32'h0);
            tick();
        end
        bus.req_valid = '0;

        // Lock: rr_ptr is 2; req1 message A1,A2,A3 while req2 waits
        set_req(1, 8'hA1, 1'b0);
        bus.req_valid = 4'b0010;
        #1;
        chk("lock_ready_a1", 32'(bus.req_ready), 32'h2);
        tick();
        set_req(1, 8'hA2, 1'b0);
        set_req(2, 8'hB2, 1'b1);
        bus.req_valid = 4'b0110;
        #1;
        chk("lock_data_a1", 32'(bus.tx_data), 32'hA1);
        chk("lock_send_ready", 32'(bus.req_ready), 32'h0);
        tick();
        chk("lock_only_grant", 32'(bus.req_ready), 32'h2);
        chk("lock_busy", 32'(bus.busy_ret), 32'h1);
        chk("lock_txreq_low", 32'(bus.tx_req), 32'h0);
        tick();
        set_req(1, 8'hA3, 1'b1);
        #1;
        chk("lock_data_a2", 32'(bus.tx_data), 32'hA2);
        tick();
        chk("lock_only_grant2", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = 4'b0100;
        #1;
        chk("lock_data_a3", 32'(bus.tx_data), 32'hA3);
        tick();
        chk("lock_next_ready", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = '0;
        #1;
        chk("lock_next_grant", 32'(bus.grant_ret), 32'h2);
        chk("lock_next_data", 32'(bus.tx_data), 32'hB2);
        tick();

        // Timeout: rr_ptr is 3; req0 locks then stalls, req3 waits
        set_req(0, 8'hC0, 1'b0);
        set_req(3, 8'hD3, 1'b1);
        bus.req_valid = 4'b0001;
        #1;
        chk("to_ready_c0", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 4'b1000;
        tick();
        for (int c = 0; c < 16; c++) begin
            chk("to_lock_busy", 32'(bus.busy_ret), 32'h1);
            chk("to_lock_ready", 32'(bus.req_ready), 32'h1);
            tick();
        end
        chk("to_released", 32'(bus.busy_ret), 32'h0);
        chk("to_req3_ready", 32'(bus.req_ready), 32'h8);
        tick();
        chk("to_req3_grant", 32'(bus.grant_ret), 32'h3);
        chk("to_req3_data", 32'(bus.tx_data), 32'hD3);
        bus.req_valid = '0;
        tick();

        // Valid in the timeout cycle keeps the lock; rr_ptr is 0
        set_req(0, 8'hE0, 1'b0);
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        for (int c = 0; c < 15; c++) tick();
        chk("edge_still_lock", 32'(bus.busy_ret), 32'h1);
        set_req(0, 8'hE1, 1'b1);
        bus.req_valid = 4'b1001;
        #1;
        chk("edge_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = '0;
        chk("edge_txreq", 32'(bus.tx_req), 32'h1);
        chk("edge_data", 32'(bus.tx_data), 32'hE1);
        tick();

        // Backpressure then reset mid-send; rr_ptr is 1
        bus.tx_cts = 1'b0;
        set_req(1, 8'hF1, 1'b1);
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 50; c++) begin
            chk("bp_txreq", 32'(bus.tx_req), 32'h1);
            chk("bp_data", 32'(bus.tx_data), 32'hF1);
            chk("bp_ready", 32'(bus.req_ready), 32'h0);
            tick();
        end
        tick_i_rstn = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        tick();
        chk("mid_rst_txreq", 32'(bus.tx_req), 32'h0);
        chk("mid_rst_busy", 32'(bus.busy_ret), 32'h0);
        chk("mid_rst_data", 32'(bus.tx_data), 32'h0);
        bus.req_valid = '0;
        bus.tx_cts    = 1'b1;
        tick_i_rstn   = 1'b1;
        tick();
        chk("post_rst_txreq", 32'(bus.tx_req), 32'h0);
        chk("post_rst_grant", 32'(bus.grant_ret), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
